// File: rtl/serial_add_pkg.sv
// Shared definitions for the slice-serial carry-lookahead adder.
// Slice width, FSM state type and index-width helper.
package serial_add_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Ceiling log2, never below 1 so a single-slice index still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// All carries are flattened generate/propagate sums-of-products.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/serial_cla_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit CLA slice per clock, LSB slice first,
// with the slice carry registered between cycles. Valid/ready on both sides.
module serial_cla_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("serial_cla_adder: WIDTH must be a positive multiple of 4");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q, ovf_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    cla4_slice u_slice (
        .a    (a_q[SLICE_W*idx_q +: SLICE_W]),
        .b    (b_q[SLICE_W*idx_q +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)          state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Running sum with the current slice merged in; the final slice's value is the result.
    always_comb begin
        acc_d = acc_q;
        acc_d[SLICE_W*idx_q +: SLICE_W] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q  <= acc_d;
                        cout_q <= slice_cout;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_cla_adder.md
Name: serial_cla_adder

Overview:
- Multi-cycle wide adder built on one 4-bit carry-lookahead slice.
- Accepts WIDTH-bit operands through a valid/ready handshake and adds one 4-bit slice per clock, least-significant slice first.
- The slice carry-out is registered and fed into the next slice's carry-in.
- Used where a full-width adder is too large. Sits upstream of result consumers, such as an accumulator or ALU writeback stage.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived; number of slice cycles per add. Not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, ovf=0.
  - Operand registers, slice index and carry register cleared.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b; carry_reg<=cin; idx<=0; go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry_reg.
  - Slice sum is written into sum_reg[4*idx+:4]; carry_reg <= slice cout; idx <= idx+1.
  - When idx==NSLICE-1, that edge also sets cout<=slice cout and ovf<=(a_reg[W-1]==b_reg[W-1]) && (new sum MSB != a_reg[W-1]), then goes to DONE.
- State DONE:
  - out_valid=1; sum/cout/ovf are stable.
  - On out_ready: go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle re-accept.
- Latency:
  - Handshake accepted at edge T; out_valid=1 in the cycle after edge T+NSLICE (4 cycles for WIDTH=16).
  - Throughput is one add per NSLICE+2 cycles with out_ready held high.
- Output holding:
  - sum/cout/ovf hold their last values in IDLE and RUN.
  - They are qualified only by out_valid.
  - Partial slice writes during RUN update the internal sum_reg; the sum port is driven from a result register loaded only on the final slice.
- Operand stability: a/b/cin are sampled only at acceptance; changes while not in IDLE are ignored.
- in_valid while busy: ignored and not queued; the upstream block must hold it until in_ready.
- Backpressure: out_ready low in DONE holds all outputs indefinitely.
- Wrap-around: the result is modulo 2^WIDTH; cout carries the lost bit. With cin=1 and all-ones operands, the carry ripples through every slice.
- Reset mid-operation: async clear to IDLE within the reset assertion; the partial result is discarded and out_valid is never asserted for the aborted add.
- Illegal WIDTH (not a multiple of 4): elaboration-time error.

Decomposition:
- Shared package serial_add_pkg:
  - SLICE_W=4.
  - State enum {IDLE, RUN, DONE}.
  - Function clog2 for idx width (max(1, clog2(NSLICE))).
- One sub-module, cla4_slice:
  - Purely combinational 4-bit carry-lookahead adder.
  - Ports a[3:0], b[3:0], cin, sum[3:0], cout.
  - Generate/propagate per bit; carries are computed in lookahead form, not rippled.
- The top level holds the FSM, operand/carry/index registers and the result registers.

Test Plan:
- Reset:
  - rst_n low then high -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- Basic add:
  - WIDTH=16, a=0x1234, b=0x4321, cin=0 accepted at edge T.
  - -> out_valid=1 after edge T+4; sum=0x5555, cout=0, ovf=0.
- Full carry ripple:
  - a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
  - Each intermediate carry_reg=1.
- Signed overflow:
  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure and busy:
  - In DONE, hold out_ready=0 for 5 cycles while in_valid=1 with new operands.
  - -> outputs stable, in_ready=0.
  - After out_ready pulse: IDLE, new operands accepted and correct.
- Reset mid-operation:
  - Assert rst_n low during RUN at idx=2 -> state IDLE immediately, out_valid=0, outputs 0.
  - Next add 0x00FF+0x0001 -> sum=0x0100, cout=0.
